// File: rtl/kick_pkg.sv
// Shared types and constants for the kick sequencer: state encoding,
// grant codes and timer width helpers.
package kick_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGING,
    S_READY,
    S_FIRING,
    S_COOLDOWN,
    S_FAULT
  } state_t;

  localparam logic [1:0] GRANT_HOST = 2'b01;
  localparam logic [1:0] GRANT_AUTO = 2'b10;

  // Bits needed to hold the longest trigger pulse, (2^pwr_w-1)*fire_unit.
  function automatic int fire_cnt_w(int pwr_w, int fire_unit);
    return $clog2(((1 << pwr_w) - 1) * fire_unit + 1);
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/kick_sequencer_if.sv
// Command/charger/solenoid signal bundle for the kick sequencer.
interface kick_sequencer_if #(parameter int PWR_W = 4);
  logic             enable;
  logic             charger_done;
  logic             req_host;
  logic [PWR_W-1:0] power_host;
  logic             req_auto;
  logic [PWR_W-1:0] power_auto;
  logic             charge;
  logic             trigger;
  logic             ready;
  logic             busy;
  logic [1:0]       grant;
  logic             fault;
  logic [7:0]       kick_count;

  modport master (
    output enable, charger_done, req_host, power_host, req_auto, power_auto,
    input  charge, trigger, ready, busy, grant, fault, kick_count
  );

  modport slave (
    input  enable, charger_done, req_host, power_host, req_auto, power_auto,
    output charge, trigger, ready, busy, grant, fault, kick_count
  );
endinterface

// File: rtl/kick_timer.sv
// Loadable down-counter shared by charge timeout, fire width and cooldown.
// expired is high while the count sits at zero.
module kick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= value;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/kick_sequencer.sv
// Kicker sequencer: charge, arbitrate host/auto requests, fire, cool down.
// Define KICK_QUEUE_EN to hold one request seen while charging or cooling.
module kick_sequencer
  import kick_pkg::*;
#(
  parameter int PWR_W          = 4,
  parameter int FIRE_UNIT      = 4096,
  parameter int COOLDOWN_CYC   = 500000,
  parameter int CHARGE_TIMEOUT = 50000000
) (
  input logic             clk,
  input logic             rst_n,
  kick_sequencer_if.slave bus
);
  localparam int TW = max3(fire_cnt_w(PWR_W, FIRE_UNIT),
                           $clog2(COOLDOWN_CYC + 1), $clog2(CHARGE_TIMEOUT + 1));

  state_t           state, state_nxt;
  logic             tmr_load, tmr_exp, fire;
  logic [TW-1:0]    tmr_val;
  logic [1:0]       gsel;
  logic             host_vld, auto_vld, req_vld;
  logic [1:0]       req_src;
  logic [PWR_W-1:0] req_pwr;

  assign host_vld = bus.req_host && (bus.power_host != '0);
  assign auto_vld = bus.req_auto && (bus.power_auto != '0);

`ifdef KICK_QUEUE_EN
  logic             pend_vld;
  logic [1:0]       pend_src;
  logic [PWR_W-1:0] pend_pwr;

  // A stored request takes precedence over live requests once READY.
  always_comb begin
    req_vld = pend_vld || host_vld || auto_vld;
    req_src = GRANT_HOST;
    req_pwr = bus.power_host;
    if (pend_vld) begin
      req_src = pend_src;
      req_pwr = pend_pwr;
    end else if (!host_vld) begin
      req_src = GRANT_AUTO;
      req_pwr = bus.power_auto;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_src <= '0;
      pend_pwr <= '0;
    end else if (!bus.enable || state == S_FAULT || fire) begin
      pend_vld <= 1'b0;
    end else if (state == S_CHARGING || state == S_COOLDOWN) begin
      if (host_vld) begin
        pend_vld <= 1'b1;
        pend_src <= GRANT_HOST;
        pend_pwr <= bus.power_host;
      end else if (auto_vld && !pend_vld) begin
        pend_vld <= 1'b1;
        pend_src <= GRANT_AUTO;
        pend_pwr <= bus.power_auto;
      end
    end
  end
`else
  always_comb begin
    req_vld = host_vld || auto_vld;
    req_src = host_vld ? GRANT_HOST : GRANT_AUTO;
    req_pwr = host_vld ? bus.power_host : bus.power_auto;
  end
`endif

  kick_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_val),
    .expired(tmr_exp)
  );

  // The timer is reloaded on the edge that enters each timed state.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    fire      = 1'b0;
    case (state)
      S_IDLE: if (bus.enable) begin
        state_nxt = S_CHARGING;
        tmr_load  = 1'b1;
        tmr_val   = TW'(CHARGE_TIMEOUT - 1);
      end
      S_CHARGING: begin
        if (!bus.enable)          state_nxt = S_IDLE;
        else if (bus.charger_done) state_nxt = S_READY;
        else if (tmr_exp)         state_nxt = S_FAULT;
      end
      S_READY: begin
        if (!bus.enable) begin
          state_nxt = S_IDLE;
        end else if (!bus.charger_done) begin
          state_nxt = S_CHARGING;
          tmr_load  = 1'b1;
          tmr_val   = TW'(CHARGE_TIMEOUT - 1);
        end else if (req_vld) begin
          state_nxt = S_FIRING;
          fire      = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = TW'(req_pwr) * TW'(FIRE_UNIT) - TW'(1);
        end
      end
      S_FIRING: if (tmr_exp) begin
        state_nxt = S_COOLDOWN;
        tmr_load  = 1'b1;
        tmr_val   = TW'(COOLDOWN_CYC - 1);
      end
      S_COOLDOWN: if (tmr_exp) begin
        if (bus.enable) begin
          state_nxt = S_CHARGING;
          tmr_load  = 1'b1;
          tmr_val   = TW'(CHARGE_TIMEOUT - 1);
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FAULT: if (!bus.enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are a registered decode of the state register, one cycle behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      gsel           <= '0;
      bus.kick_count <= '0;
      bus.charge     <= 1'b0;
      bus.trigger    <= 1'b0;
      bus.ready      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.fault      <= 1'b0;
      bus.grant      <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        gsel           <= req_src;
        bus.kick_count <= bus.kick_count + 8'd1;
      end
      bus.charge  <= (state == S_CHARGING) || (state == S_READY);
      bus.trigger <= (state == S_FIRING);
      bus.ready   <= (state == S_READY);
      bus.busy    <= (state == S_FIRING) || (state == S_COOLDOWN);
      bus.fault   <= (state == S_FAULT);
      bus.grant   <= (state == S_FIRING) ? gsel : 2'b00;
    end
  end
endmodule
